// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads on the shared
// memory port, presents {inst, pc} to IF/ID and follows decode-stage redirects.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_a_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_din_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {F0, F1, F2, F3, W} state_t;

  state_t          r_state;
  logic [31:0]     r_pc;
  logic            r_pend;
  logic [1:0]      r_pidx;
  logic [2:0][7:0] r_buf;
  logic [31:0]     r_inst;
  logic [31:0]     r_pc_o;
  logic            r_valid;

  logic [1:0]      w_k;
  logic            w_acc;

  always_comb begin
    w_k       = 2'd0;
    mem_req_o = 1'b0;
    case (r_state)
      F0: mem_req_o = !r_valid || !stall_i;
      F1: begin mem_req_o = 1'b1; w_k = 2'd1; end
      F2: begin mem_req_o = 1'b1; w_k = 2'd2; end
      F3: begin mem_req_o = 1'b1; w_k = 2'd3; end
      default: mem_req_o = 1'b0;
    endcase
  end

  assign mem_a_o      = r_pc + {30'd0, w_k};
  assign w_acc        = mem_req_o && mem_gnt_i;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc_o;
  assign inst_valid_o = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= F0;
      r_pend  <= 1'b0;
      r_pidx  <= 2'd0;
      r_buf   <= '0;
      r_inst  <= 32'd0;
      r_pc_o  <= 32'd0;
      r_valid <= 1'b0;
    end else if (branch_flag_i) begin
      // Redirect drops any in-flight byte and flushes the wrong-path word.
      r_pc    <= branch_target_i;
      r_state <= F0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (r_pend) begin
        case (r_pidx)
          2'd0:    r_buf[0] <= mem_din_i;
          2'd1:    r_buf[1] <= mem_din_i;
          2'd2:    r_buf[2] <= mem_din_i;
          default: ;
        endcase
      end
      if (r_valid && !stall_i)
        r_valid <= 1'b0;
      case (r_state)
        F0, F1, F2, F3: begin
          r_pend <= w_acc;
          if (w_acc) begin
            r_pidx <= w_k;
            case (r_state)
              F0:      r_state <= F1;
              F1:      r_state <= F2;
              F2:      r_state <= F3;
              default: r_state <= W;
            endcase
          end
        end
        default: begin
          // Byte 3 is consumed straight off the bus; output is guaranteed free here.
          r_inst  <= {mem_din_i, r_buf[2], r_buf[1], r_buf[0]};
          r_pc_o  <= r_pc;
          r_valid <= 1'b1;
          r_pc    <= r_pc + 32'd4;
          r_state <= F0;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed per-cycle vector tables for if_fetch against a byte memory that answers
// one cycle after acceptance and drives 8'hEE otherwise.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_a_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_din_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        stall_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  int total = 0;
  int bad   = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .mem_req_o(mem_req_o), .mem_a_o(mem_a_o),
    .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .stall_i(stall_i), .inst_o(inst_o),
    .pc_o(pc_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  // Bytes 0..3 hold addi a0,x0,1 (00100513); everything else is addr[7:0]^A5.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk)
    mem_din_i <= (mem_req_o && mem_gnt_i) ? mem_byte(mem_a_o) : 8'hEE;

  typedef struct {
    bit          rst, gnt, stall, br;
    logic [31:0] tgt;
    bit          e_req;
    logic [31:0] e_a;
    bit          e_v, chk_o;
    logic [31:0] e_inst, e_pc;
  } vec_t;

  vec_t q[$];

  function automatic vec_t V(bit r, bit g, bit s, bit b, logic [31:0] t, bit req,
                             logic [31:0] a, bit v, bit co, logic [31:0] in, logic [31:0] p);
    vec_t x;
    x.rst = r; x.gnt = g; x.stall = s; x.br = b; x.tgt = t;
    x.e_req = req; x.e_a = a; x.e_v = v; x.chk_o = co || v; x.e_inst = in; x.e_pc = p;
    return x;
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc%0d got %h want %h", nm, c, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_gnt_i = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
    @(posedge clk); #3;
    chk("rst_valid", -1, {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", -1, inst_o, 32'd0);
    chk("rst_pc", -1, pc_o, 32'd0);
    chk("rst_addr", -1, mem_a_o, 32'd0);
    chk("rst_req", -1, {31'd0, mem_req_o}, 32'd1);
  endtask

  task automatic run(input string nm);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      rst = q[i].rst; mem_gnt_i = q[i].gnt; stall_i = q[i].stall;
      branch_flag_i = q[i].br; branch_target_i = q[i].tgt;
      #3;
      chk({nm, "_req"}, i, {31'd0, mem_req_o}, {31'd0, q[i].e_req});
      chk({nm, "_addr"}, i, mem_a_o, q[i].e_a);
      chk({nm, "_valid"}, i, {31'd0, inst_valid_o}, {31'd0, q[i].e_v});
      if (q[i].chk_o) begin
        chk({nm, "_inst"}, i, inst_o, q[i].e_inst);
        chk({nm, "_pc"}, i, pc_o, q[i].e_pc);
      end
    end
    q.delete();
  endtask

  // Cycles 0..4 of a fully granted fetch from pc 0.
  task automatic basic_head();
    q.push_back(V(0,1,0,0,0, 1,32'd0,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd1,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd2,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd3,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 0,32'd0,0,0,0,0));
  endtask

  localparam logic [31:0] I0   = 32'h00100513;
  localparam logic [31:0] I4   = 32'hA2A3A0A1;
  localparam logic [31:0] I100 = 32'hA6A7A4A5;
  localparam logic [31:0] I40  = 32'hE6E7E4E5;
  localparam logic [31:0] IWR  = 32'h05135A5B;

  initial begin
    rst = 1'b1; mem_gnt_i = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;

    // basic fetch
    do_reset();
    basic_head();
    q.push_back(V(0,1,0,0,0, 1,32'd4,1,1,I0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd5,0,0,0,0));
    run("basic");

    // grant gaps in cycles 1-2
    do_reset();
    q.push_back(V(0,1,0,0,0, 1,32'd0,0,0,0,0));
    q.push_back(V(0,0,0,0,0, 1,32'd1,0,0,0,0));
    q.push_back(V(0,0,0,0,0, 1,32'd1,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd1,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd2,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd3,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 0,32'd0,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd4,1,1,I0,0));
    run("gap");

    // stall in cycles 5-8
    do_reset();
    basic_head();
    for (int c = 5; c <= 8; c++) q.push_back(V(0,1,1,0,0, 0,32'd4,1,1,I0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd4,1,1,I0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd5,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd6,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd7,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 0,32'd4,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd8,1,1,I4,32'd4));
    run("stall");

    // branch to 0x100 in cycle 7 (F2 of pc 4)
    do_reset();
    basic_head();
    q.push_back(V(0,1,0,0,0, 1,32'd4,1,1,I0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd5,0,0,0,0));
    q.push_back(V(0,1,0,1,32'h100, 1,32'd6,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'h100,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'h101,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'h102,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'h103,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 0,32'h100,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'h104,1,1,I100,32'h100));
    run("branch");

    // branch to 0x40 while the output is held by stall
    do_reset();
    basic_head();
    q.push_back(V(0,1,1,1,32'h40, 0,32'd4,1,1,I0,0));
    q.push_back(V(0,1,1,0,0, 1,32'h40,0,0,0,0));
    q.push_back(V(0,1,1,0,0, 1,32'h41,0,0,0,0));
    q.push_back(V(0,1,1,0,0, 1,32'h42,0,0,0,0));
    q.push_back(V(0,1,1,0,0, 1,32'h43,0,0,0,0));
    q.push_back(V(0,1,1,0,0, 0,32'h40,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'h44,1,1,I40,32'h40));
    run("brstall");

    // branch during W flushes the completing word; target fetch wraps past 2^32
    do_reset();
    q.push_back(V(0,1,0,0,0, 1,32'd0,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd1,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd2,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd3,0,0,0,0));
    q.push_back(V(0,1,0,1,32'hFFFF_FFFE, 0,32'd0,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'hFFFF_FFFE,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'hFFFF_FFFF,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd0,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd1,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 0,32'hFFFF_FFFE,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd2,1,1,IWR,32'hFFFF_FFFE));
    run("wrap");

    // reset in F2 of pc 4; outputs return to reset values, fetch restarts at 0
    do_reset();
    basic_head();
    q.push_back(V(0,1,0,0,0, 1,32'd4,1,1,I0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd5,0,0,0,0));
    q.push_back(V(1,1,0,0,0, 1,32'd6,0,1,I0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd0,0,1,32'd0,32'd0));
    q.push_back(V(0,1,0,0,0, 1,32'd1,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd2,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd3,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 0,32'd0,0,0,0,0));
    q.push_back(V(0,1,0,0,0, 1,32'd4,1,1,I0,0));
    run("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit for the 5-stage RV32I core. It holds the PC and reads each instruction as four little-endian bytes over the shared byte-wide memory port. It presents the assembled word and its PC to the IF/ID register. It is redirected by the branch/jump outputs of the decode stage, and it is the producer of that stage's `pc_i`/`inst_i` and the consumer of its `branch_flag_o`/`branch_target_address_o`.

## Interface
- `RESET_PC`, default 32'h0, PC loaded on reset.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high.
- `mem_req_o` output 1: read request, combinational from state.
- `mem_a_o` output 32: byte address of request, combinational: `pc + k` in state Fk, else `pc`.
- `mem_gnt_i` input 1: arbiter grant. A request is accepted at an edge where `mem_req_o & mem_gnt_i`.
- `mem_din_i` input 8: read byte, valid in the cycle after acceptance.
- `branch_flag_i` input 1: redirect request from decode.
- `branch_target_i` input 32: redirect address, used unmodified, with no alignment check.
- `stall_i` input 1: IF/ID cannot accept this cycle.
- `inst_o` output 32: fetched instruction, registered.
- `pc_o` output 32: address of `inst_o`, registered.
- `inst_valid_o` output 1: `inst_o`/`pc_o` valid, registered.

## Operation
- **State:**
  - `pc` (32).
  - FSM states F0, F1, F2, F3, W.
  - `pend` (1): an accepted read is in flight.
  - `pidx` (2): byte index of that read.
  - `buf0`..`buf2` (8 each).
- **Reset values:**
  - `pc` = `RESET_PC`, state = F0, `pend` = 0.
  - `inst_o` = 0, `pc_o` = 0, `inst_valid_o` = 0.
- **Accept:** `acc = inst_valid_o & !stall_i`. On `acc`, `inst_valid_o` clears next edge unless set again by a completion.
- **Request rules:**
  - F0 drives `mem_req_o = !inst_valid_o | !stall_i`.
  - F1–F3 drive `mem_req_o = 1`.
  - W drives `mem_req_o = 0`.
- **Transitions:**
  - Fk advances to Fk+1 (F3 to W) only on acceptance. Otherwise it holds with the same address.
  - Acceptance sets `pend = 1` and `pidx = k`. Without acceptance, `pend = 0`.
- **Capture:** when `pend = 1`, `mem_din_i` is written to `buf[pidx]` for `pidx` 0–2.
- **Completion (W):** W always lasts exactly one cycle and captures byte 3. At its edge:
  - `inst_o = {mem_din_i, buf2, buf1, buf0}`.
  - `pc_o = pc`, `inst_valid_o = 1`.
  - `pc = pc + 4` (mod 2^32).
  - State returns to F0.
- **Output occupancy:** completion never finds the output occupied, because F0 only issues when the output is empty or being accepted.
- **Redirect:** `branch_flag_i` has priority over all else except `rst`. At that edge:
  - `pc = branch_target_i`, state = F0.
  - `pend = 0`, so a byte arriving next cycle is discarded.
  - `inst_valid_o = 0`, flushing the wrong-path word even if stalled or completing in W.
  - Buffers are don't-care.
- **Redirect in the same cycle as a request:** the request is still presented, and its data is ignored.
- **Reset mid-fetch:** same discard as redirect. Fetch restarts at `RESET_PC`.

## Timing
- Cycle 0 is the first cycle with `rst` low.
- Full grant:
  - Addresses `pc`..`pc+3` in cycles 0–3, W in cycle 4.
  - `inst_valid_o` high in cycle 5.
  - Next fetch requests `pc+4` in cycle 5.
  - Throughput is 1 instruction per 5 cycles.
- Each cycle of `mem_gnt_i = 0` during a request adds one cycle of latency.
- **Stall:** while `inst_valid_o & stall_i`, outputs hold, `mem_req_o = 0`, and the FSM stays in F0. The first cycle with `stall_i = 0` both accepts and issues `pc+0` of the next fetch.
- **Redirect latency:** `branch_flag_i` in cycle n gives `mem_a_o = branch_target_i` in cycle n+1. With full grant, the target instruction is valid in cycle n+6.
- `mem_a_o` wraps modulo 2^32 (`pc = 32'hFFFF_FFFE` requests FFFF_FFFE, FFFF_FFFF, 0, 1).

## Test plan
- **Basic fetch:** `RESET_PC = 0`, memory bytes 13,05,10,00 at 0–3, grant always, no stall. Required:
  - `mem_a_o` = 0,1,2,3 in cycles 0–3.
  - `mem_req_o` low in cycle 4.
  - Cycle 5: `inst_valid_o = 1`, `inst_o = 32'h00100513`, `pc_o = 0`, `mem_a_o = 4`.
  - Cycle 6: `inst_valid_o = 0`.
- **Grant gaps:** as above with `mem_gnt_i = 0` in cycles 1–2. Required: `mem_a_o = 1` held in cycles 1–3; valid in cycle 7 with the same word.
- **Stall:** as the basic fetch with `stall_i = 1` in cycles 5–8. Required:
  - Outputs and valid held through cycle 8.
  - `mem_req_o = 0` in cycles 5–8.
  - Address 4 issued in cycle 9, valid low in cycle 10, next valid in cycle 14 with `pc_o = 4`.
- **Branch mid-fetch:** `branch_flag_i = 1`, target 32'h100 in cycle 7 (state F2 of pc 4). Required: cycle 8 `mem_a_o = 32'h100`; valid in cycle 13 with `pc_o = 32'h100` and bytes from 100–103 only.
- **Branch while output stalled:** `inst_valid_o = 1` and `stall_i = 1`, branch to 32'h40. Required: valid low next cycle, fetch from 32'h40, no stale word ever presented.
- **Reset mid-fetch:** `rst` high in state F2. Required: all outputs at reset values; the first post-reset word comes from `RESET_PC` bytes, and the in-flight byte is unused.
